// File: rtl/ifns_tx_scheduler.sv
// Transmit sequencer for the IFNS 4b->5b crosstalk-avoidance code: slices each
// accepted word into nibbles and streams one registered codeword per cycle.

module encoderIFNS_4di_core (
  input  logic [3:0] d_i,
  output logic [4:0] c_o
);
  // The 16 five-bit words free of 010/101 patterns, in ascending order.
  always_comb begin
    c_o = 5'b00000;
    case (d_i)
      4'h0:    c_o = 5'b00000;
      4'h1:    c_o = 5'b00001;
      4'h2:    c_o = 5'b00011;
      4'h3:    c_o = 5'b00110;
      4'h4:    c_o = 5'b00111;
      4'h5:    c_o = 5'b01100;
      4'h6:    c_o = 5'b01110;
      4'h7:    c_o = 5'b01111;
      4'h8:    c_o = 5'b10000;
      4'h9:    c_o = 5'b10001;
      4'hA:    c_o = 5'b10011;
      4'hB:    c_o = 5'b11000;
      4'hC:    c_o = 5'b11001;
      4'hD:    c_o = 5'b11100;
      4'hE:    c_o = 5'b11110;
      4'hF:    c_o = 5'b11111;
      default: c_o = 5'b00000;
    endcase
  end
endmodule

module ifns_tx_scheduler #(
  parameter int NIBBLES   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4:0]             out_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q;
  logic [W-1:0]    buf_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      code_q;
  logic            valid_q;
  logic            last_q;
  logic            advance_s;
  logic [3:0]      nib_s;
  logic [4:0]      code_d;

  function automatic logic [3:0] pick_nibble(input logic [W-1:0] word, input logic [CW-1:0] k);
    int pos;
    pos = (MSB_FIRST != 0) ? (NIBBLES - 1 - int'(k)) : int'(k);
    return word[4*pos +: 4];
  endfunction

  assign advance_s = ~valid_q | out_ready;
  assign in_ready  = ~rst & advance_s & (state_q == IDLE);
  assign out_code  = code_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q == SEND) | valid_q;

  // In IDLE the core sees nibble 0 of the incoming word so it can be captured on acceptance.
  always_comb begin
    if (state_q == SEND) begin
      nib_s = pick_nibble(buf_q, cnt_q);
    end else begin
      nib_s = pick_nibble(in_data, '0);
    end
  end

  encoderIFNS_4di_core u_core (
    .d_i (nib_s),
    .c_o (code_d)
  );

  // Sequencer and output register; out_code is left untouched when idle to hold the bus.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      code_q  <= 5'b00000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (advance_s) begin
            if (in_valid) begin
              code_q  <= code_d;
              valid_q <= 1'b1;
              last_q  <= (NIBBLES == 1);
              buf_q   <= in_data;
              cnt_q   <= (NIBBLES > 1) ? CW'(1) : '0;
              state_q <= (NIBBLES > 1) ? SEND : IDLE;
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end
          end
        end
        SEND: begin
          if (advance_s) begin
            code_q  <= code_d;
            valid_q <= 1'b1;
            last_q  <= (cnt_q == LAST_IDX);
            if (cnt_q == LAST_IDX) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
